uart_rx_engine: RTL and testbench

UART_RX_ENGINE -- requirements
Module: uart_rx_engine

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_engine.sv | 159 +++++++++++++++
 tb/tb_uart_rx_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive engine: FSM state encoding and
// oversampling / frame constants. Optional parity support is enabled by
// defining UART_RX_PARITY_EN.
package uart_pkg;

    localparam int OVERSAMPLE_MID  = 7;
    localparam int OVERSAMPLE_LAST = 15;
    localparam int DATA_BITS       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..baud_div-1 and pulses tick on the
// last count. A baud_div of 0 behaves as 1. restart realigns the count to 0
// so sampling phase follows the start edge.
module uart_baud_tick (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [15:0] baud_div,
    input  logic        restart,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] div_last;

    assign div_last = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;

    // The >= compare keeps the counter bounded if baud_div shrinks mid-count.
    assign tick = !restart && (cnt_q >= div_last);

    // Tick counter with wrap and restart.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!ARESETN) begin
            cnt_q <= 16'd0;
        end else if (restart || cnt_q >= div_last) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine, 16x oversampled, 8 data bits LSB-first, one stop bit.
// Holds one received byte behind a valid/ready handshake and flags framing
// and overrun errors. Define UART_RX_PARITY_EN to add a parity bit between
// the data and stop bits (parity_odd selects odd parity, parity_err flags it).
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [15:0] baud_div,
    input  logic        rx_in,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
`ifdef UART_RX_PARITY_EN
    input  logic        parity_odd,
    output logic        parity_err,
`endif
    output logic        frame_err,
    output logic        overrun_err,
    output logic        busy
);

    localparam int SC_W = $clog2(OVERSAMPLE);

    uart_state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      rxs;
    logic                      tick;
    logic [SC_W-1:0]           sc_q;
    logic [2:0]                bc_q;
    logic [DATA_BITS-1:0]      shift_q;

    logic restart, at_mid, at_last;
    logic shift_en, start_ok, stop_smp, commit, frame_bad;
`ifdef UART_RX_PARITY_EN
    logic par_smp, par_bad_q;
`endif

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign at_mid  = tick && (sc_q == SC_W'(OVERSAMPLE_MID));
    assign at_last = tick && (sc_q == SC_W'(OVERSAMPLE_LAST));

    uart_baud_tick u_baud_tick (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .baud_div (baud_div),
        .restart  (restart),
        .tick     (tick)
    );

    // Metastability synchronizer for the asynchronous line, idle-high reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) sync_q <= '1;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (!rxs) state_d = ST_START;
            ST_START:     if (at_mid) state_d = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:
                if (at_last && bc_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
            ST_PARITY:    if (at_last) state_d = ST_STOP;
`endif
            ST_STOP:      if (at_last) state_d = rxs ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (rxs) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM output decode: datapath strobes and busy.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        restart   = (state_q == ST_IDLE) && !rxs;
        start_ok  = (state_q == ST_START) && at_mid && !rxs;
        shift_en  = (state_q == ST_DATA) && at_last;
        stop_smp  = (state_q == ST_STOP) && at_last;
        commit    = stop_smp && rxs;
        frame_bad = stop_smp && !rxs;
`ifdef UART_RX_PARITY_EN
        par_smp   = (state_q == ST_PARITY) && at_last;
`endif
    end

    // Sub-bit, bit and shift registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sc_q    <= '0;
            bc_q    <= '0;
            shift_q <= '0;
        end else begin
            if (restart) begin
                sc_q <= '0;
                bc_q <= '0;
            end else if (tick && busy) begin
                sc_q <= (start_ok || at_last) ? '0 : sc_q + SC_W'(1);
            end
            if (shift_en) begin
                shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                bc_q    <= bc_q + 3'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity check result, held until the stop bit is sampled.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)     par_bad_q <= 1'b0;
        else if (restart) par_bad_q <= 1'b0;
        else if (par_smp) par_bad_q <= ((^shift_q) ^ rxs) != parity_odd;
    end
`endif

    // Output holding register, handshake and error pulses.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_err   <= frame_bad;
            overrun_err <= commit && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
            parity_err  <= stop_smp && par_bad_q;
`endif
            if (commit && !(rx_valid && !rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed frames plus randomized
// bytes, baud divisors and gaps, compared against a byte-queue model.
`timescale 1ns/1ps
module tb_uart_rx_engine;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [15:0] baud_div;
    logic        rx_in;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun_err;
    logic        busy;
`ifdef UART_RX_PARITY_EN
    logic        parity_odd;
    logic        parity_err;
`endif

    uart_rx_engine dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .baud_div    (baud_div),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
`ifdef UART_RX_PARITY_EN
        .parity_odd  (parity_odd),
        .parity_err  (parity_err),
`endif
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int div_eff = 1;

    // Monitor results
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int frame_cnt = 0, over_cnt = 0, par_cnt = 0, vrise_cnt = 0;
    int long_pulse = 0, unstable = 0;
    int t_start = 0, t_rise = 0;
    logic prev_valid = 0, prev_hs = 0, prev_fe = 0, prev_oe = 0, prev_pe = 0;
    logic [7:0] prev_data = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge ACLK) cyc++;

    always @(negedge ACLK) begin
        logic pe_now;
        pe_now = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_now = parity_err;
`endif
        if (ARESETN) begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (rx_valid && !prev_valid) begin vrise_cnt++; t_rise = cyc; end
            if (frame_err && !prev_fe) frame_cnt++;
            if (overrun_err && !prev_oe) over_cnt++;
            if (pe_now && !prev_pe) par_cnt++;
            if ((frame_err && prev_fe) || (overrun_err && prev_oe) || (pe_now && prev_pe))
                long_pulse++;
            if (prev_valid && rx_valid && !prev_hs && rx_data != prev_data) unstable++;
        end
        prev_valid = rx_valid;
        prev_hs    = rx_valid && rx_ready;
        prev_data  = rx_data;
        prev_fe    = frame_err;
        prev_oe    = overrun_err;
        prev_pe    = pe_now;
    end

    task automatic set_div(input int d);
        baud_div = 16'(d);
        div_eff  = (d == 0) ? 1 : d;
    endtask

    task automatic drive_bit(input logic v, input int cycles);
        rx_in = v;
        repeat (cycles) @(posedge ACLK);
        #1;
    endtask

    // Drives start, 8 data bits LSB-first, optional parity, stop.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        int t;
        t = 16 * div_eff;
        @(posedge ACLK); #1;
        t_start = cyc;
        drive_bit(1'b0, t);
        for (int i = 0; i < 8; i++) drive_bit(b[i], t);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ parity_odd ^ par_flip, t);
`else
        if (par_flip) t = t;
`endif
        drive_bit(stop_bit, t);
        rx_in = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20000) begin @(posedge ACLK); n++; end
        #1;
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        int f0, o0, p0, v0, lat;
        logic [7:0] b55;
        ARESETN  = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b1;
        set_div(4);
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame", frame_err, 0);
        check("rst_overrun", overrun_err, 0);
        ARESETN = 1'b1;
        repeat (5) @(posedge ACLK);

        // Single 0xA5 frame and its latency from the start edge
        got.delete(); v0 = vrise_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (8) @(posedge ACLK); #1;
        check("a5_count", got.size(), 1);
        check("a5_data", (got.size() > 0) ? got[0] : 8'h00, 8'hA5);
        check("a5_pulses", vrise_cnt - v0, 1);
        lat = t_rise - t_start;
        check("a5_latency_ok", (lat >= 600 && lat <= 620), 1);
        check("a5_valid_low", rx_valid, 0);

        // False start: line low 20 cycles
        got.delete(); f0 = frame_cnt;
        @(posedge ACLK); #1;
        drive_bit(1'b0, 20);
        rx_in = 1'b1;
        repeat (60) @(posedge ACLK); #1;
        check("fs_busy", busy, 0);
        check("fs_novalid", got.size(), 0);
        check("fs_noframe", frame_cnt - f0, 0);

        // Framing error with a break held afterwards
        got.delete(); f0 = frame_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b0, 3 * 16 * div_eff);
        check("fe_pulse", frame_cnt - f0, 1);
        check("fe_wait_high_busy", busy, 1);
        check("fe_novalid", rx_valid, 0);
        rx_in = 1'b1;
        repeat (10) @(posedge ACLK); #1;
        check("fe_idle", busy, 0);
        check("fe_nobyte", got.size(), 0);

        // Overrun: two bytes back-to-back, consumer stalled
        got.delete(); o0 = over_cnt;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (8) @(posedge ACLK); #1;
        check("ov_pulse", over_cnt - o0, 1);
        check("ov_keep_data", rx_data, 8'h11);
        check("ov_valid", rx_valid, 1);
        rx_ready = 1'b1;
        repeat (3) @(posedge ACLK); #1;
        check("ov_valid_drop", rx_valid, 0);
        check("ov_count", got.size(), 1);
        check("ov_first", (got.size() > 0) ? got[0] : 8'h00, 8'h11);

        // Reset during bit 4 of 0x55, then 0x0F
        got.delete(); f0 = frame_cnt; o0 = over_cnt;
        b55 = 8'h55;
        @(posedge ACLK); #1;
        drive_bit(1'b0, 16 * div_eff);
        for (int i = 0; i < 4; i++) drive_bit(b55[i], 16 * div_eff);
        drive_bit(b55[4], 8 * div_eff);
        ARESETN = 1'b0;
        #1;
        check("mr_busy_rst", busy, 0);
        repeat (3) @(posedge ACLK); #1;
        rx_in = 1'b1;
        ARESETN = 1'b1;
        repeat (40) @(posedge ACLK);
        send_frame(8'h0F, 1'b1, 1'b0);
        repeat (8) @(posedge ACLK); #1;
        check("mr_count", got.size(), 1);
        check("mr_data", (got.size() > 0) ? got[0] : 8'h00, 8'h0F);
        check("mr_noerr", (frame_cnt - f0) + (over_cnt - o0), 0);

`ifdef UART_RX_PARITY_EN
        // Bad even parity on 0x01 still commits the byte
        got.delete(); p0 = par_cnt;
        parity_odd = 1'b0;
        send_frame(8'h01, 1'b1, 1'b1);
        repeat (8) @(posedge ACLK); #1;
        check("par_pulse", par_cnt - p0, 1);
        check("par_data", (got.size() > 0) ? got[0] : 8'h00, 8'h01);
`endif

        // Randomized bytes, divisors and inter-frame gaps
        got.delete(); exp_q.delete();
        f0 = frame_cnt; o0 = over_cnt; p0 = par_cnt;
        for (int n = 0; n < 10; n++) begin
            logic [7:0] b;
            b = 8'($urandom);
            set_div($urandom_range(0, 5));
`ifdef UART_RX_PARITY_EN
            parity_odd = 1'($urandom);
`endif
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b0);
            repeat ($urandom_range(0, 48 * div_eff)) @(posedge ACLK);
        end
        wait_idle();
        repeat (8) @(posedge ACLK); #1;
        check("rnd_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rnd_byte%0d", i), (i < got.size()) ? got[i] : 9'h100, exp_q[i]);
        check("rnd_noerr", (frame_cnt - f0) + (over_cnt - o0) + (par_cnt - p0), 0);

        check("pulse_width", long_pulse, 0);
        check("data_stable", unstable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
